// File: rtl/sr_pkg.sv
// Shared definitions for the SR serial link (PISO transmitter / SIPO receiver).
package sr_pkg;

  localparam int SR_WIDTH_DEFAULT = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } sr_state_e;

endpackage

// File: rtl/sr_sipo_rx_if.sv
// Parallel-word handshake between the SIPO receiver (master) and its consumer (slave).
interface sr_sipo_rx_if #(
  parameter int WIDTH = sr_pkg::SR_WIDTH_DEFAULT
);

  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);

endinterface

// File: rtl/sr_sipo_core.sv
// Shift register, bit counter and framing FSM; word_done/word are combinational
// so the holding register can capture the completed word on the completing edge.
module sr_sipo_core
  import sr_pkg::*;
#(
  parameter int WIDTH     = SR_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] word,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sr_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] base, shifted;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    word_done = 1'b0;

    // A resynchronising bit starts from an empty register.
    base    = frame_start ? '0 : sreg_q;
    shifted = MSB_FIRST ? {base[WIDTH-2:0], sin} : {sin, base[WIDTH-1:1]};

    if (frame_start) begin
      if (sin_valid) begin
        sreg_d  = shifted;
        cnt_d   = CW'(1);
        state_d = ST_SHIFT;
      end else begin
        sreg_d  = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    end else if (sin_valid) begin
      sreg_d = shifted;
      if (cnt_q == LAST) begin
        cnt_d     = '0;
        state_d   = ST_IDLE;
        word_done = 1'b1;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        state_d = ST_SHIFT;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      busy    <= (state_d == ST_SHIFT);
    end
  end

  assign word = shifted;

endmodule

// File: rtl/sr_sipo_rx.sv
// SIPO receiver top: framing core plus holding register, valid/ready handshake
// and sticky overrun flag.
module sr_sipo_rx
  import sr_pkg::*;
#(
  parameter int WIDTH     = SR_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sin,
  input  logic               sin_valid,
  input  logic               frame_start,
  sr_sipo_rx_if.master       out_if,
  output logic               overrun,
  input  logic               overrun_clr,
  output logic               busy
);

  logic [WIDTH-1:0] word;
  logic             word_done;

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             accept;

  sr_sipo_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .sin         (sin),
    .sin_valid   (sin_valid),
    .frame_start (frame_start),
    .word        (word),
    .word_done   (word_done),
    .busy        (busy)
  );

  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q & ~overrun_clr;
    accept  = valid_q & out_if.dout_ready;

    if (word_done) begin
      // Load only if the slot is free or being emptied this edge; else drop.
      if (!valid_q || accept) begin
        dout_d  = word;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_if.dout       = dout_q;
  assign out_if.dout_valid = valid_q;
  assign overrun           = ovr_q;

endmodule

// File: tb/tb_sr_sipo_rx.sv
// Bench for sr_sipo_rx: MSB-first and LSB-first instances share stimulus and
// are checked against a bit-queue reference model plus hand-derived vectors.
module tb_sr_sipo_rx;
  import sr_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset, sin, sin_valid, frame_start, rdy, ovr_clr;
  logic ovr_m, ovr_l, busy_m, busy_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sr_sipo_rx_if #(.WIDTH(W)) if_m ();
  sr_sipo_rx_if #(.WIDTH(W)) if_l ();

  assign if_m.dout_ready = rdy;
  assign if_l.dout_ready = rdy;

  sr_sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid),
    .frame_start(frame_start), .out_if(if_m.master), .overrun(ovr_m),
    .overrun_clr(ovr_clr), .busy(busy_m)
  );

  sr_sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid),
    .frame_start(frame_start), .out_if(if_l.master), .overrun(ovr_l),
    .overrun_clr(ovr_clr), .busy(busy_l)
  );

  // Reference model: pending bits kept in arrival order.
  bit         q_bits[$];
  bit [W-1:0] m_hold_m, m_hold_l;
  bit         m_valid, m_ovr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(input bit r, input bit s, input bit sv,
                                     input bit fs, input bit rd, input bit cl);
    bit         done, accept, set_ovr;
    bit [W-1:0] wm, wl;
    done = 1'b0; set_ovr = 1'b0; wm = '0; wl = '0;
    if (r) begin
      q_bits.delete();
      m_hold_m = '0; m_hold_l = '0; m_valid = 1'b0; m_ovr = 1'b0;
      return;
    end
    if (fs) begin
      q_bits.delete();
      if (sv) q_bits.push_back(s);
    end else if (sv) begin
      q_bits.push_back(s);
      if (q_bits.size() == W) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = q_bits[i];
          wl[i]     = q_bits[i];
        end
        q_bits.delete();
      end
    end
    accept = m_valid && rd;
    if (done) begin
      if (!m_valid || accept) begin
        m_hold_m = wm; m_hold_l = wl; m_valid = 1'b1;
      end else begin
        set_ovr = 1'b1;
      end
    end else if (accept) begin
      m_valid = 1'b0;
    end
    m_ovr = set_ovr ? 1'b1 : (cl ? 1'b0 : m_ovr);
  endfunction

  task automatic cycle(input logic r, input logic s, input logic sv, input logic fs,
                       input logic rd, input logic cl, input string tag);
    reset = r; sin = s; sin_valid = sv; frame_start = fs; rdy = rd; ovr_clr = cl;
    model_step(r, s, sv, fs, rd, cl);
    @(posedge clk);
    #1;
    check({tag, ":dout_m"},  32'(if_m.dout),       32'(m_hold_m));
    check({tag, ":dout_l"},  32'(if_l.dout),       32'(m_hold_l));
    check({tag, ":valid_m"}, 32'(if_m.dout_valid), 32'(m_valid));
    check({tag, ":valid_l"}, 32'(if_l.dout_valid), 32'(m_valid));
    check({tag, ":busy"},    32'({busy_m, busy_l}), {30'd0, {2{q_bits.size() != 0}}});
    check({tag, ":ovr"},     32'({ovr_m, ovr_l}),   {30'd0, {2{m_ovr}}});
  endtask

  task automatic send(input logic s, input logic rd, input string tag);
    cycle(1'b0, s, 1'b1, 1'b0, rd, 1'b0, tag);
  endtask

  task automatic idle(input logic rd, input string tag);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, rd, 1'b0, tag);
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] dm, input logic v,
                            input logic b, input logic o);
    check({tag, ":x_dout"},  32'(if_m.dout),       32'(dm));
    check({tag, ":x_valid"}, 32'(if_m.dout_valid), 32'(v));
    check({tag, ":x_busy"},  32'(busy_m),          32'(b));
    check({tag, ":x_ovr"},   32'(ovr_m),           32'(o));
  endtask

  typedef struct {
    logic       sin, sv, fs, rdy, clr;
    logic [3:0] em, el;
    logic       ev, eb, eo;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Basic word 1,0,1,0 then LSB-first check word 1,0,0,0; ready held high.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1010, 4'b0101, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1010, 4'b0101, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1010, 4'b0101, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1010, 4'b0101, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1010, 4'b0101, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, 4'b0001, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1000, 4'b0001, 1'b0, 1'b0, 1'b0};

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "reset");
    expect_out("reset_state", 4'b0000, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, tbl[i].sin, tbl[i].sv, tbl[i].fs, tbl[i].rdy, tbl[i].clr, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d:e_dout_m", i), 32'(if_m.dout), 32'(tbl[i].em));
      check($sformatf("tbl%0d:e_dout_l", i), 32'(if_l.dout), 32'(tbl[i].el));
      check($sformatf("tbl%0d:e_flags", i), 32'({if_m.dout_valid, busy_m, ovr_m}),
            32'({tbl[i].ev, tbl[i].eb, tbl[i].eo}));
    end

    // Gapped strobes: 0,1,1,0 with three idle cycles after each of the first three.
    send(1'b0, 1'b1, "gap");
    for (int g = 0; g < 3; g++) idle(1'b1, "gap");
    expect_out("gap_b1", 4'b1000, 1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b1, "gap");
    for (int g = 0; g < 3; g++) idle(1'b1, "gap");
    send(1'b1, 1'b1, "gap");
    for (int g = 0; g < 3; g++) idle(1'b1, "gap");
    expect_out("gap_b3", 4'b1000, 1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b1, "gap");
    expect_out("gap_done", 4'b0110, 1'b1, 1'b0, 1'b0);
    idle(1'b1, "gap");

    // Back-pressure: second word dropped; clear requested on the same edge loses.
    send(1'b0, 1'b0, "bp"); send(1'b0, 1'b0, "bp"); send(1'b1, 1'b0, "bp"); send(1'b0, 1'b0, "bp");
    expect_out("bp_first", 4'b0010, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, "bp"); send(1'b1, 1'b0, "bp"); send(1'b1, 1'b0, "bp");
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "bp");
    expect_out("bp_drop", 4'b0010, 1'b1, 1'b0, 1'b1);
    idle(1'b1, "bp");
    expect_out("bp_accept", 4'b0010, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "bp");
    expect_out("bp_clr", 4'b0010, 1'b0, 1'b0, 1'b0);

    // Completion and acceptance on the same edge.
    send(1'b0, 1'b0, "sim"); send(1'b0, 1'b0, "sim"); send(1'b0, 1'b0, "sim"); send(1'b1, 1'b0, "sim");
    expect_out("sim_first", 4'b0001, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, "sim"); send(1'b0, 1'b0, "sim"); send(1'b0, 1'b0, "sim");
    send(1'b0, 1'b1, "sim");
    expect_out("sim_both", 4'b1000, 1'b1, 1'b0, 1'b0);
    idle(1'b1, "sim");

    // frame_start with a strobe restarts the word.
    send(1'b1, 1'b1, "fs"); send(1'b1, 1'b1, "fs");
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "fs");
    expect_out("fs_restart", 4'b1000, 1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b1, "fs"); send(1'b1, 1'b1, "fs"); send(1'b1, 1'b1, "fs");
    expect_out("fs_word", 4'b0011, 1'b1, 1'b0, 1'b0);
    idle(1'b1, "fs");

    // frame_start beats completion when WIDTH-1 bits are pending.
    send(1'b1, 1'b1, "fs3"); send(1'b1, 1'b1, "fs3"); send(1'b1, 1'b1, "fs3");
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "fs3");
    expect_out("fs3_nodone", 4'b0011, 1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b1, "fs3"); send(1'b0, 1'b1, "fs3"); send(1'b0, 1'b1, "fs3");
    expect_out("fs3_word", 4'b1000, 1'b1, 1'b0, 1'b0);
    idle(1'b1, "fs3");

    // frame_start without a strobe just discards.
    send(1'b1, 1'b1, "fs0");
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "fs0");
    expect_out("fs0_idle", 4'b1000, 1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b1, "fs0"); send(1'b1, 1'b1, "fs0"); send(1'b0, 1'b1, "fs0"); send(1'b1, 1'b1, "fs0");
    expect_out("fs0_word", 4'b0101, 1'b1, 1'b0, 1'b0);

    // Reset mid-word.
    send(1'b1, 1'b0, "rst"); send(1'b1, 1'b0, "rst");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst");
    expect_out("rst_mid", 4'b0000, 1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b1, "rst"); send(1'b1, 1'b1, "rst"); send(1'b1, 1'b1, "rst"); send(1'b0, 1'b1, "rst");
    expect_out("rst_word", 4'b0110, 1'b1, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      cycle(1'($urandom_range(0, 199) == 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) == 0),
            "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_sipo_rx.md
Name: sr_sipo_rx

Overview:
- Serial-in/parallel-out receive register. It is the receiving end of the team's PISO serial link.
- Collects WIDTH serial bits, qualified by a bit strobe, into a word.
- Presents each completed word on a holding register with a valid/ready handshake.
- Flags overrun when a new word completes while the previous word is still unconsumed.

Parameters:
- WIDTH, 4, bits per word; legal range is 2 or more.
- MSB_FIRST, 1. When 1, the first received bit lands in dout[WIDTH-1]. When 0, the first received bit lands in dout[0].

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sin  in  1  serial data bit, sampled only when sin_valid=1.
- sin_valid  in  1  bit strobe; one bit consumed per cycle in which it is high.
- frame_start  in  1  resynchronises the word boundary.
- dout  out  WIDTH  assembled word in the holding register.
- dout_valid  out  1  holding register contains an unconsumed word.
- dout_ready  in  1  consumer accepts dout on the edge where dout_valid=1 and dout_ready=1.
- overrun  out  1  sticky flag: a completed word was dropped.
- overrun_clr  in  1  clears overrun.
- busy  out  1  partial word in progress (bit count is nonzero).

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high, and has priority over all other inputs.
  - Reset values: dout=0, dout_valid=0, overrun=0, busy=0, shift register=0, bit count=0, FSM=IDLE.
  - Reset mid-word discards the partial word; there is no output activity.
- Shift path:
  - On an edge with sin_valid=1, the shift register takes sin.
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], sin}.
  - MSB_FIRST=0: sreg <= {sin, sreg[WIDTH-1:1]}.
  - The bit count increments; it is log2-sized and covers 0..WIDTH-1.
- FSM:
  - IDLE (count=0). sin_valid -> SHIFT with count=1.
  - SHIFT (1 ≤ count ≤ WIDTH-1).
  - sin_valid with count=WIDTH-1 means the word completes: count returns to 0 and the FSM goes to IDLE.
  - Cycles with sin_valid=0 hold all state. Gaps between bits are unlimited.
- busy = (FSM==SHIFT), registered.
- frame_start:
  - With sin_valid=1: the current bit is bit 0 of a new word, and the partial word is discarded. count=1, FSM=SHIFT, and the stored bit is placed per the shift rule from a cleared register.
  - With sin_valid=0: count=0, FSM=IDLE, partial word discarded.
  - With WIDTH-1 bits pending and sin_valid=1: frame_start wins, and no word completes.
- Word completion: on the completing edge, the full word (including the current bit) is written to dout and dout_valid=1 in the same edge. dout is visible the cycle after the last bit is strobed, i.e. latency is 1 cycle from the final sin_valid.
- Handshake:
  - dout_valid and dout stay stable until they are accepted.
  - An acceptance edge with no completion sets dout_valid to 0; dout retains its last value.
  - Completion with dout_valid=0: load the word and set dout_valid to 1.
  - Completion together with acceptance on the same edge: load the new word; dout_valid stays 1; no overrun.
  - Completion with dout_valid=1 and dout_ready=0: the new word is dropped, dout is unchanged, and overrun is set to 1.
- overrun:
  - Sticky; cleared by overrun_clr on an edge.
  - If a set condition and overrun_clr occur on the same edge, set wins.
- dout_ready while dout_valid=0 is ignored.

Decomposition:
- Shared package sr_pkg:
  - FSM state encoding constants ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - Default WIDTH constant, shared with the PISO transmitter.
- One natural sub-module: sr_sipo_core, covering shift register, bit counter, FSM and frame_start handling, with a word_done pulse output.
- The top level adds the holding register, handshake logic and overrun flag.

Test Plan:
- Basic word (WIDTH=4, MSB_FIRST=1, dout_ready=1): bits 1,0,1,0 on consecutive cycles -> next cycle dout=4'b1010, dout_valid=1 for exactly 1 cycle; busy high during bits 2-4 only.
- Gapped strobes: bits 0,1,1,0 with 3 idle cycles between each -> dout=4'b0110 only after the 4th strobe; dout and busy stable during gaps.
- Back-pressure (dout_ready=0):
  - Word 4'b0010 followed by word 4'b1111 -> dout stays 4'b0010 and overrun=1.
  - Then dout_ready=1 -> dout_valid=0.
  - Then overrun_clr -> overrun=0.
- Completion plus simultaneous accept: hold 4'b0001 valid, and assert dout_ready on the edge the second word 4'b1000 completes -> dout=4'b1000, dout_valid stays 1, overrun=0.
- frame_start resync:
  - Send 1,1, then frame_start+sin_valid with sin=0, then 0,1,1 -> dout=4'b0011, no word from the discarded bits.
  - Reset after 2 bits -> busy=0, dout_valid=0, next 4 bits form a clean word.
- LSB-first variant (MSB_FIRST=0): bits 1,0,0,0 -> dout=4'b0001.
